// File: rtl/mrv32_dmem_if.sv
// LSU <-> data-memory bus: single-cycle request strobe and a one-cycle read response.
interface mrv32_dmem_if #(
    parameter int ADDR_WIDTH = 32
) ();

    logic                  b_valid;   // request strobe
    logic [ADDR_WIDTH-1:0] b_addr;    // byte address, bits [1:0] ignored
    logic [31:0]           b_wdata;   // write data, lanes pre-positioned
    logic [3:0]            b_wstrb;   // byte enables, all-zero means read
    logic [31:0]           b_rdata;   // read word, valid with b_rvalid
    logic                  b_rvalid;  // one-cycle read response pulse

    // Requester side (the LSU).
    modport master (
        output b_valid, b_addr, b_wdata, b_wstrb,
        input  b_rdata, b_rvalid
    );

    // Responder side (the data memory).
    modport slave (
        input  b_valid, b_addr, b_wdata, b_wstrb,
        output b_rdata, b_rvalid
    );

endinterface

// File: rtl/mrv32_dmem_resp.sv
// Data-memory responder: word-organised RAM with byte-strobed writes and full-word reads
// returned after a fixed read latency. Flags requests made while busy and requests
// outside the RAM with sticky error bits.
module mrv32_dmem_resp #(
    parameter int ADDR_WIDTH   = 32,
    parameter int MEM_BYTES    = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    mrv32_dmem_if.slave   bus,
    output logic          busy_o,
    output logic          err_proto_o,
    output logic          err_oob_o,
    input  logic          clr_err_i
);

    localparam int WORDS = MEM_BYTES / 4;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    // Compared one bit wider than the address so MEM_BYTES == 2**ADDR_WIDTH still works.
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_BYTES);

    // WAIT runs READ_LATENCY-1 cycles, counting lat_cnt down to zero.
    localparam logic [2:0] LAT_INIT = (READ_LATENCY >= 2) ? 3'(READ_LATENCY - 2) : 3'd0;

    // Reject illegal configurations at elaboration.
    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
            $error("mrv32_dmem_resp: READ_LATENCY must be in 1..8");
        end
        if (MEM_BYTES < 8 || (MEM_BYTES % 4) != 0) begin : g_bad_size
            $error("mrv32_dmem_resp: MEM_BYTES must be a multiple of 4 and at least 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    // Storage and registered state.
    logic [31:0]  mem [WORDS];
    state_t       state_q;
    logic [2:0]   lat_cnt_q;
    logic [31:0]  snap_q;
    logic [31:0]  rdata_q;
    logic         rvalid_q;
    logic         busy_q;
    logic         err_proto_q, err_proto_d;
    logic         err_oob_q,   err_oob_d;

    // Request decode.
    logic             in_range;
    logic             is_write;
    logic             accept;
    logic             wr_en;
    logic             rd_accept;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      rd_word;

    assign in_range  = ({1'b0, bus.b_addr} < MEM_LIMIT);
    assign is_write  = |bus.b_wstrb;
    assign word_idx  = bus.b_addr[IDX_W+1:2];
    // Only IDLE accepts work; anything arriving in WAIT/RESP is dropped.
    assign accept    = bus.b_valid && (state_q == S_IDLE);
    assign wr_en     = accept && is_write && in_range;
    assign rd_accept = accept && !is_write;
    // Out-of-range reads return zero instead of an aliased word.
    assign rd_word   = in_range ? mem[word_idx] : 32'd0;

    // Byte-lane write into the RAM.
    // NOTE: the RAM array has no reset so it maps onto a plain memory macro; its
    // contents are undefined until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.b_wstrb[i]) begin
                    mem[word_idx][8*i +: 8] <= bus.b_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read sequencer: IDLE -> (WAIT) -> RESP -> IDLE with registered outputs.
    // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge
    // values of state_q/lat_cnt_q regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            lat_cnt_q <= 3'd0;
            snap_q    <= 32'd0;
            rdata_q   <= 32'd0;
            rvalid_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rd_accept) begin
                        busy_q <= 1'b1;
                        if (READ_LATENCY == 1) begin
                            // Snapshot goes straight to the output on entry to RESP.
                            state_q  <= S_RESP;
                            rdata_q  <= rd_word;
                            rvalid_q <= 1'b1;
                        end else begin
                            state_q   <= S_WAIT;
                            snap_q    <= rd_word;
                            lat_cnt_q <= LAT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (lat_cnt_q == 3'd0) begin
                        state_q  <= S_RESP;
                        rdata_q  <= snap_q;
                        rvalid_q <= 1'b1;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 3'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error next-state: a new error wins over a same-cycle clear.
    // NOTE: every output of this block gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        err_proto_d = err_proto_q;
        err_oob_d   = err_oob_q;
        if (clr_err_i) begin
            err_proto_d = 1'b0;
            err_oob_d   = 1'b0;
        end
        if (bus.b_valid && (state_q != S_IDLE)) begin
            err_proto_d = 1'b1;
        end
        if (bus.b_valid && !in_range) begin
            err_oob_d = 1'b1;
        end
    end

    // Sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_proto_q <= 1'b0;
            err_oob_q   <= 1'b0;
        end else begin
            err_proto_q <= err_proto_d;
            err_oob_q   <= err_oob_d;
        end
    end

    assign bus.b_rdata  = rdata_q;
    assign bus.b_rvalid = rvalid_q;
    assign busy_o       = busy_q;
    assign err_proto_o  = err_proto_q;
    assign err_oob_o    = err_oob_q;

endmodule

// File: tb/tb_mrv32_dmem_resp.sv
// Directed bench for mrv32_dmem_resp: one instance with READ_LATENCY=1 and one with
// READ_LATENCY=4 share the stimulus; sel routes requests and observation to one of them.
module tb_mrv32_dmem_resp;

    localparam int AW  = 32;
    localparam int MEM = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus.
    logic          sel = 1'b0;   // 0: latency-1 DUT, 1: latency-4 DUT
    logic          valid = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          clr_err = 1'b0;

    mrv32_dmem_if #(.ADDR_WIDTH(AW)) bus1 ();
    mrv32_dmem_if #(.ADDR_WIDTH(AW)) bus4 ();

    assign bus1.b_valid = valid & ~sel;
    assign bus1.b_addr  = addr;
    assign bus1.b_wdata = wdata;
    assign bus1.b_wstrb = wstrb;
    assign bus4.b_valid = valid & sel;
    assign bus4.b_addr  = addr;
    assign bus4.b_wdata = wdata;
    assign bus4.b_wstrb = wstrb;

    logic busy1, ep1, eo1, busy4, ep4, eo4;

    mrv32_dmem_resp #(.ADDR_WIDTH(AW), .MEM_BYTES(MEM), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .busy_o(busy1), .err_proto_o(ep1), .err_oob_o(eo1), .clr_err_i(clr_err)
    );

    mrv32_dmem_resp #(.ADDR_WIDTH(AW), .MEM_BYTES(MEM), .READ_LATENCY(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4),
        .busy_o(busy4), .err_proto_o(ep4), .err_oob_o(eo4), .clr_err_i(clr_err)
    );

    // Observation of the selected DUT.
    wire [31:0] rdata  = sel ? bus4.b_rdata  : bus1.b_rdata;
    wire        rvalid = sel ? bus4.b_rvalid : bus1.b_rvalid;
    wire        busy   = sel ? busy4 : busy1;
    wire        eproto = sel ? ep4 : ep1;
    wire        eoob   = sel ? eo4 : eo1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one request for one cycle; returns just after the accepting edge.
    task automatic req(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        valid = 1'b1;
        addr  = a;
        wdata = d;
        wstrb = s;
        step();
        valid = 1'b0;
        wstrb = 4'b0000;
    endtask

    // Wait (bounded) for b_rvalid; reports cycles waited.
    task automatic wait_rvalid(input int max_cyc, output int cyc);
        cyc = 0;
        while (!rvalid && cyc < max_cyc) begin
            step();
            cyc++;
        end
        if (!rvalid) check("rvalid_timeout", 32'(rvalid), 32'd1);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
    endtask

    int cyc;
    int stray;

    initial begin
        // Reset state of both instances.
        step(2);
        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            #1;
            check("rst_rdata",  rdata, 32'd0);
            check("rst_rvalid", 32'(rvalid), 32'd0);
            check("rst_busy",   32'(busy), 32'd0);
            check("rst_eproto", 32'(eproto), 32'd0);
            check("rst_eoob",   32'(eoob), 32'd0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Latency 1: full-word write, read back one cycle later.
        req(32'h100, 32'hDEADBEEF, 4'b1111);
        check("wr_no_rvalid", 32'(rvalid), 32'd0);
        check("wr_not_busy", 32'(busy), 32'd0);
        req(32'h100, 32'h0, 4'b0000);
        check("l1_rvalid", 32'(rvalid), 32'd1);
        check("l1_rdata", rdata, 32'hDEADBEEF);
        check("l1_busy_resp", 32'(busy), 32'd1);
        step();
        check("l1_pulse_end", 32'(rvalid), 32'd0);
        check("l1_rdata_hold", rdata, 32'hDEADBEEF);
        check("l1_idle", 32'(busy), 32'd0);

        // Low address bits are ignored.
        req(32'h103, 32'h0, 4'b0000);
        check("unaligned_rd", rdata, 32'hDEADBEEF);
        step();

        // Byte strobes; each read immediately follows its write.
        req(32'h40, 32'h11223344, 4'b1111);
        req(32'h40, 32'h00AA0000, 4'b0100);
        req(32'h40, 32'h0, 4'b0000);
        check("strb_0100", rdata, 32'h11AA3344);
        step();
        req(32'h40, 32'h55FFFF66, 4'b1001);
        req(32'h40, 32'h0, 4'b0000);
        check("strb_1001", rdata, 32'h55AA3366);
        step();
        check("l1_no_proto", 32'(eproto), 32'd0);

        // Out-of-range: read returns 0 with normal latency; write must not alias into 0x40.
        req(MEM, 32'h0, 4'b0000);
        check("oob_rvalid", 32'(rvalid), 32'd1);
        check("oob_rdata", rdata, 32'd0);
        check("oob_flag", 32'(eoob), 32'd1);
        step();
        req(MEM + 32'h40, 32'hFFFFFFFF, 4'b1111);
        req(32'h40, 32'h0, 4'b0000);
        check("oob_wr_dropped", rdata, 32'h55AA3366);
        step();
        pulse_clr();
        check("clr_oob", 32'(eoob), 32'd0);
        check("clr_proto", 32'(eproto), 32'd0);
        // Set wins over a same-cycle clear.
        clr_err = 1'b1;
        req(MEM + 32'h4, 32'h0, 4'b0000);
        clr_err = 1'b0;
        check("set_over_clr", 32'(eoob), 32'd1);
        step();
        pulse_clr();
        check("clr_again", 32'(eoob), 32'd0);

        // Latency 4: pulse only at T+4, busy T+1..T+4, rdata stable beforehand.
        sel = 1'b1;
        step();
        req(32'h10, 32'hCAFEF00D, 4'b1111);
        req(32'h10, 32'h0, 4'b0000);
        for (int t = 1; t <= 5; t++) begin
            check($sformatf("l4_rvalid_t%0d", t), 32'(rvalid), (t == 4) ? 32'd1 : 32'd0);
            check($sformatf("l4_busy_t%0d", t), 32'(busy), (t <= 4) ? 32'd1 : 32'd0);
            check($sformatf("l4_rdata_t%0d", t), rdata, (t >= 4) ? 32'hCAFEF00D : 32'd0);
            if (t < 5) step();
        end

        // Write during WAIT is dropped and flagged; the in-flight read is unchanged.
        req(32'h10, 32'h0, 4'b0000);
        req(32'h10, 32'h12345678, 4'b1111);
        check("proto_flag", 32'(eproto), 32'd1);
        wait_rvalid(8, cyc);
        check("proto_lat", 32'(cyc), 32'd2);
        check("proto_rdata", rdata, 32'hCAFEF00D);
        step();
        req(32'h10, 32'h0, 4'b0000);
        wait_rvalid(8, cyc);
        check("proto_wr_dropped", rdata, 32'hCAFEF00D);
        step();
        pulse_clr();
        check("proto_clr", 32'(eproto), 32'd0);

        // Reset during WAIT cancels the read.
        req(32'h20, 32'h0BADF00D, 4'b1111);
        req(32'h20, 32'h0, 4'b0000);
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rvalid", 32'(rvalid), 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rvalid) stray++;
        end
        check("midrst_no_pulse", 32'(stray), 32'd0);
        req(32'h20, 32'h0, 4'b0000);
        wait_rvalid(8, cyc);
        check("post_rst_lat", 32'(cyc), 32'd3);
        check("post_rst_rdata", rdata, 32'h0BADF00D);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
